// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared mode encodings, default rates and divider sizing helper
//               for the stopwatch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_PAUSED = 2'b01,
        ST_ADJUST = 2'b10
    } state_t;

    localparam int unsigned c_DEF_CLK_HZ          = 100_000_000;
    localparam int unsigned c_DEF_INC_HZ          = 1;
    localparam int unsigned c_DEF_ADJ_HZ          = 2;
    localparam int unsigned c_DEF_BLINK_HZ        = 4;
    localparam int unsigned c_DEF_SCAN_HZ         = 500;
    localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 2_000_000;

    // Width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : debounce
// Description : 2-flop synchronizer, stability counter and registered
//               one-cycle pulse on each debounced rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned          c_CNT_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_TC = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_deb;
    logic               r_deb_d;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
            // Any bounce back to the accepted level restarts the stability window
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_TC) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Stopwatch mode FSM with debounced buttons, count/adjust/blink
//               enables and free-running display scan strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ          = c_DEF_CLK_HZ,
    parameter int unsigned INC_HZ          = c_DEF_INC_HZ,
    parameter int unsigned ADJ_HZ          = c_DEF_ADJ_HZ,
    parameter int unsigned BLINK_HZ        = c_DEF_BLINK_HZ,
    parameter int unsigned SCAN_HZ         = c_DEF_SCAN_HZ,
    parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       inc_en,
    output logic       adj_en,
    output logic       adj_sel,
    output logic       clr,
    output logic       blink,
    output logic       scan_en,
    output logic [1:0] state
);

    localparam int unsigned c_INC_DIV = CLK_HZ / INC_HZ;
    localparam int unsigned c_ADJ_DIV = CLK_HZ / ADJ_HZ;
    localparam int unsigned c_BLK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned c_SCN_DIV = CLK_HZ / SCAN_HZ;

    localparam int unsigned c_INC_W = cnt_width(c_INC_DIV);
    localparam int unsigned c_ADJ_W = cnt_width(c_ADJ_DIV);
    localparam int unsigned c_BLK_W = cnt_width(c_BLK_DIV);
    localparam int unsigned c_SCN_W = cnt_width(c_SCN_DIV);

    localparam logic [c_INC_W-1:0] c_INC_TC = c_INC_W'(c_INC_DIV - 1);
    localparam logic [c_ADJ_W-1:0] c_ADJ_TC = c_ADJ_W'(c_ADJ_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_TC = c_BLK_W'(c_BLK_DIV - 1);
    localparam logic [c_SCN_W-1:0] c_SCN_TC = c_SCN_W'(c_SCN_DIV - 1);

    logic               w_pause_press;
    logic               w_clr_press;

    state_t             r_state;
    state_t             r_saved;
    logic               r_adj_s1, r_adj_s2;
    logic               r_sel_s1, r_sel_s2;
    logic [c_INC_W-1:0] r_inc_cnt;
    logic [c_ADJ_W-1:0] r_adj_cnt;
    logic [c_BLK_W-1:0] r_blk_cnt;
    logic [c_SCN_W-1:0] r_scn_cnt;
    logic               r_inc_en, r_adj_en, r_clr, r_blink, r_scan_en;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_pause (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_pause),
        .o_press (w_pause_press)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbn_clr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_rst),
        .o_press (w_clr_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_saved   <= ST_RUN;
            r_adj_s1  <= 1'b0;
            r_adj_s2  <= 1'b0;
            r_sel_s1  <= 1'b0;
            r_sel_s2  <= 1'b0;
            r_inc_cnt <= '0;
            r_adj_cnt <= '0;
            r_blk_cnt <= '0;
            r_scn_cnt <= '0;
            r_inc_en  <= 1'b0;
            r_adj_en  <= 1'b0;
            r_clr     <= 1'b0;
            r_blink   <= 1'b0;
            r_scan_en <= 1'b0;
        end else begin
            r_adj_s1 <= sw_adj;
            r_adj_s2 <= r_adj_s1;
            r_sel_s1 <= sw_sel;
            r_sel_s2 <= r_sel_s1;

            if (r_scn_cnt == c_SCN_TC) begin
                r_scn_cnt <= '0;
                r_scan_en <= 1'b1;
            end else begin
                r_scn_cnt <= r_scn_cnt + c_SCN_W'(1);
                r_scan_en <= 1'b0;
            end

            // A clear press takes precedence over the terminal count
            r_clr    <= w_clr_press;
            r_inc_en <= 1'b0;
            if (w_clr_press) begin
                r_inc_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                if (r_inc_cnt == c_INC_TC) begin
                    r_inc_cnt <= '0;
                    r_inc_en  <= 1'b1;
                end else begin
                    r_inc_cnt <= r_inc_cnt + c_INC_W'(1);
                end
            end

            r_adj_en <= 1'b0;
            case (r_state)
                ST_RUN, ST_PAUSED: begin
                    r_adj_cnt <= '0;
                    r_blk_cnt <= '0;
                    r_blink   <= 1'b0;
                    if (r_adj_s2) begin
                        r_saved <= r_state;
                        r_state <= ST_ADJUST;
                    end else if (w_pause_press) begin
                        r_state <= (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
                    end
                end
                ST_ADJUST: begin
                    if (!r_adj_s2) begin
                        r_state   <= r_saved;
                        r_adj_cnt <= '0;
                        r_blk_cnt <= '0;
                        r_blink   <= 1'b0;
                    end else begin
                        if (r_adj_cnt == c_ADJ_TC) begin
                            r_adj_cnt <= '0;
                            r_adj_en  <= 1'b1;
                        end else begin
                            r_adj_cnt <= r_adj_cnt + c_ADJ_W'(1);
                        end
                        if (r_blk_cnt == c_BLK_TC) begin
                            r_blk_cnt <= '0;
                            r_blink   <= ~r_blink;
                        end else begin
                            r_blk_cnt <= r_blk_cnt + c_BLK_W'(1);
                        end
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign inc_en  = r_inc_en;
    assign adj_en  = r_adj_en;
    assign adj_sel = r_sel_s2;
    assign clr     = r_clr;
    assign blink   = r_blink;
    assign scan_en = r_scan_en;
    assign state   = r_state;

endmodule
`default_nettype wire
